muldiv_unit: RTL

//  Parametrised iterative multiply/divide unit for the RV32IM/RV64IM M-extension, placed in
//  the EX stage beside the ALU. Accepts one op per START, computes MUL/MULH/MULHSU/MULHU by

---
 rtl/muldiv_unit_if.sv | 34 +++
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
// Handshake bundle between the EX stage (master) and the iterative
// multiply/divide unit (slave).
//   start        : issue an op (sampled only while the unit is idle/done)
//   flush        : abort any op in flight (branch/jump redirect)
//   funct3       : M-extension opcode selector
//   operand1/2   : rs1 / rs2
//   busy         : unit is iterating, pipeline must hold EX
//   result_valid : one-cycle pulse, result valid in this cycle
//   result       : last completed result, held between ops
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, operand1, operand2,
    input  busy, result_valid, result
  );

  modport slave (
    input  start, flush, funct3, operand1, operand2,
    output busy, result_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32IM/RV64IM M-extension unit. Multiplies by shift-add and
// divides by restoring division, one bit per cycle, on operand magnitudes;
// signs are applied in a final FIX cycle.
// Ports:
//   i_clk   : clock, all state on rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : muldiv_unit_if.slave (start/flush/funct3/operands in,
//             busy/result_valid/result out)
// Configuration macro: MULDIV_FAST_MUL_EN -- when defined, multiplies use a
//   single-cycle full-width multiplier and complete on the issue edge.
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  muldiv_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2:0] F_MUL = 3'b000;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic            r_busy;
  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_m;       // multiplicand (mul) or divisor (div)
  logic [XLEN-1:0] r_hi;      // product high half / partial remainder
  logic [XLEN-1:0] r_lo;      // multiplier -> product low / dividend -> quotient
  logic            r_neg;     // product or quotient must be negated
  logic            r_neg_rem; // remainder must be negated (dividend sign)

  // ---- issue-time decode --------------------------------------------------
  logic            w_is_div;
  logic            w_op1_neg;
  logic            w_op2_neg;
  logic [XLEN-1:0] w_op1_mag;
  logic [XLEN-1:0] w_op2_mag;
  logic            w_neg;
  logic            w_div_zero;
  logic            w_overflow;
  logic            w_short;
  logic [XLEN-1:0] w_short_result;

  assign w_is_div = bus.funct3[2];
  // MULHSU treats rs2 as unsigned; MULHU/DIVU/REMU treat both as unsigned.
  assign w_op1_neg = bus.operand1[XLEN-1] &
                     (w_is_div ? ~bus.funct3[0] : (bus.funct3 != 3'b011));
  assign w_op2_neg = bus.operand2[XLEN-1] &
                     (w_is_div ? ~bus.funct3[0] : ~bus.funct3[1]);
  assign w_op1_mag = w_op1_neg ? -bus.operand1 : bus.operand1;
  assign w_op2_mag = w_op2_neg ? -bus.operand2 : bus.operand2;
  assign w_neg     = w_op1_neg ^ w_op2_neg;

  assign w_div_zero = w_is_div && (bus.operand2 == '0);
  assign w_overflow = w_is_div && !bus.funct3[0] &&
                      (bus.operand1 == MIN_NEG) && (bus.operand2 == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_raw;
  logic [2*XLEN-1:0] w_fast_s;
  logic [XLEN-1:0]   w_fast_result;
  assign w_fast_raw    = {{XLEN{1'b0}}, w_op1_mag} * {{XLEN{1'b0}}, w_op2_mag};
  assign w_fast_s      = w_neg ? -w_fast_raw : w_fast_raw;
  assign w_fast_result = (bus.funct3 == F_MUL) ? w_fast_s[XLEN-1:0]
                                               : w_fast_s[2*XLEN-1:XLEN];
  assign w_short       = w_div_zero || w_overflow || !w_is_div;
`else
  assign w_short       = w_div_zero || w_overflow;
`endif

  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_short_result = '0;
    if (w_div_zero)
      w_short_result = bus.funct3[1] ? bus.operand1 : '1;
    else if (w_overflow)
      w_short_result = bus.funct3[1] ? '0 : bus.operand1;
`ifdef MULDIV_FAST_MUL_EN
    else if (!w_is_div)
      w_short_result = w_fast_result;
`endif
  end

  // ---- one iteration ------------------------------------------------------
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_tmp;
  logic            w_div_ge;
  logic [XLEN-1:0] w_div_diff;

  assign w_mul_sum  = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_m : {XLEN{1'b0}})};
  assign w_div_tmp  = {r_hi, r_lo[XLEN-1]};
  assign w_div_ge   = (w_div_tmp >= {1'b0, r_m});
  // Difference is below the divisor, so the low XLEN bits are exact.
  assign w_div_diff = w_div_tmp[XLEN-1:0] - r_m;

  // ---- sign fix-up and result select ----------------------------------------
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_fix_result;

  assign w_prod_s = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo_s  = r_neg ? -r_lo : r_lo;
  assign w_rem_s  = r_neg_rem ? -r_hi : r_hi;

  always_comb begin
    w_fix_result = '0;
    case (r_funct3)
      3'b000:         w_fix_result = w_prod_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         w_fix_result = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: w_fix_result = w_quo_s;
      default:        w_fix_result = w_rem_s;
    endcase
  end

  // ---- FSM and datapath registers -------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: datapath registers are reset too; the block is small and known state eases debug.
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_funct3  <= '0;
      r_m       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (bus.flush) begin
      // Flush beats a simultaneous start; the result register is left alone.
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_valid <= 1'b0;
          if (bus.start) begin
            r_funct3  <= bus.funct3;
            r_neg     <= w_neg;
            r_neg_rem <= w_op1_neg;
            r_cnt     <= '0;
            if (w_short) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b1;
              r_result <= w_short_result;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
              r_m     <= w_is_div ? w_op2_mag : w_op1_mag;
              r_hi    <= '0;
              r_lo    <= w_is_div ? w_op1_mag : w_op2_mag;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (r_funct3[2]) begin
            r_hi <= w_div_ge ? w_div_diff : w_div_tmp[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_div_ge};
          end else begin
            r_hi <= w_mul_sum[XLEN:1];
            r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(XLEN-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_result;
          r_busy   <= 1'b0;
          r_valid  <= 1'b1;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.result_valid = r_valid;
  assign bus.result       = r_result;

endmodule
